rgb_video_capture: RTL and testbench

Receive-side counterpart of the LCD RGB output path. The block samples a parallel RGB565 video stream (vs/hs/de plus 16-bit pixel), frames it on vertical sync, and packs pixel pairs into 32-bit words. Words go through an internal first-word-fall-through FIFO to a valid/ready write port that feeds the frame-buffer writer. It also measures active width/height per frame and flags FIFO overflow, so the display stack can be looped back and checked in hardware.

---
 rtl/rgb_video_capture.sv | 241 ++++++++++++++++++++++++
 tb/tb_rgb_video_capture.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_video_capture.sv
// RGB565 video capture: frames the stream on vertical sync, packs pixel pairs into
// 32-bit words through a first-word-fall-through FIFO, and measures active width/height.
module rgb_video_capture #(
  parameter bit VS_POL     = 1'b1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        capture_en,
  input  logic        ovf_clr,
  input  logic        vid_vs,
  input  logic        vid_hs,
  input  logic        vid_de,
  input  logic [15:0] vid_rgb,
  output logic [31:0] wr_data,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic        frame_start,
  output logic        frame_done,
  output logic [10:0] h_meas,
  output logic [10:0] v_meas,
  output logic        meas_valid,
  output logic        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_FRAME   = 2'd2
  } state_t;

  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    sat_inc = (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  state_t      state_r, state_n;
  logic        vs_q_r, vs_qq_r, hs_q_r, hs_qq_r, de_q_r, de_qq_r;
  logic [15:0] rgb_q_r;
  logic        vs_edge_s, de_fall_s, pack_en_s;
  logic        frame_start_s, frame_done_s;
  logic        phase_r, pair_vld_r;
  logic [15:0] low_r;
  logic [31:0] pair_r;
  logic        push_s, pop_s, full_s, wr_en_s, drop_s;
  logic [31:0] push_data_s;
  logic [10:0] px_cnt_r, line_cnt_r, h_cap_r;
  logic [31:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] count_r, count_n;

  // input capture and edge-detect pipeline
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      vs_q_r  <= ~VS_POL;
      vs_qq_r <= ~VS_POL;
      hs_q_r  <= 1'b0;
      hs_qq_r <= 1'b0;
      de_q_r  <= 1'b0;
      de_qq_r <= 1'b0;
      rgb_q_r <= 16'h0000;
    end else begin
      vs_q_r  <= vid_vs;
      vs_qq_r <= vs_q_r;
      hs_q_r  <= vid_hs;
      hs_qq_r <= hs_q_r;
      de_q_r  <= vid_de;
      de_qq_r <= de_q_r;
      rgb_q_r <= vid_rgb;
    end
  end

  assign vs_edge_s = (vs_q_r == VS_POL) && (vs_qq_r != VS_POL);
  assign de_fall_s = !de_q_r && de_qq_r;
  // The cycle that sees the frame edge belongs to neither frame.
  assign pack_en_s = (state_r == ST_FRAME) && !vs_edge_s;

  // FSM state register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // FSM next-state and frame pulse decode
  always_comb begin
    state_n       = state_r;
    frame_start_s = 1'b0;
    frame_done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (capture_en) state_n = ST_WAIT_VS;
        else            state_n = ST_IDLE;
      end
      ST_WAIT_VS: begin
        if (vs_edge_s) begin
          state_n       = ST_FRAME;
          frame_start_s = 1'b1;
        end else begin
          state_n = ST_WAIT_VS;
        end
      end
      ST_FRAME: begin
        if (vs_edge_s) begin
          frame_done_s = 1'b1;
          if (capture_en) begin
            state_n       = ST_FRAME;
            frame_start_s = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          state_n = ST_FRAME;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // registered frame pulses
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_start <= frame_start_s;
      frame_done  <= frame_done_s;
    end
  end

  // pixel pair packing; completed pairs are staged one cycle so that full pairs and
  // odd-line tails reach the FIFO with the same latency
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      phase_r    <= 1'b0;
      low_r      <= 16'h0000;
      pair_r     <= 32'h0000_0000;
      pair_vld_r <= 1'b0;
    end else begin
      pair_vld_r <= 1'b0;
      if (!pack_en_s) begin
        phase_r <= 1'b0;
      end else if (de_q_r) begin
        if (phase_r) begin
          pair_r     <= {rgb_q_r, low_r};
          pair_vld_r <= 1'b1;
          phase_r    <= 1'b0;
        end else begin
          low_r   <= rgb_q_r;
          phase_r <= 1'b1;
        end
      end else if (de_fall_s) begin
        phase_r <= 1'b0;
      end else begin
        phase_r <= phase_r;
      end
    end
  end

  // A staged pair and an odd-line tail can never coincide: the tail needs phase=1 at
  // de_fall, and the pixel that staged a pair left phase at 0.
  assign push_s      = pair_vld_r || (pack_en_s && de_fall_s && phase_r);
  assign push_data_s = pair_vld_r ? pair_r : {16'h0000, low_r};

  // width/height measurement
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      px_cnt_r   <= 11'd0;
      line_cnt_r <= 11'd0;
      h_cap_r    <= 11'd0;
      h_meas     <= 11'd0;
      v_meas     <= 11'd0;
      meas_valid <= 1'b0;
    end else if ((state_r == ST_FRAME) && vs_edge_s) begin
      h_meas     <= h_cap_r;
      v_meas     <= line_cnt_r;
      meas_valid <= 1'b1;
      px_cnt_r   <= 11'd0;
      line_cnt_r <= 11'd0;
      h_cap_r    <= 11'd0;
    end else if (state_r != ST_FRAME) begin
      px_cnt_r   <= 11'd0;
      line_cnt_r <= 11'd0;
      h_cap_r    <= 11'd0;
    end else if (de_q_r) begin
      px_cnt_r <= sat_inc(px_cnt_r);
    end else if (de_fall_s) begin
      if (line_cnt_r == 11'd0) h_cap_r <= px_cnt_r;
      px_cnt_r   <= 11'd0;
      line_cnt_r <= sat_inc(line_cnt_r);
    end else if (hs_q_r != hs_qq_r) begin
      px_cnt_r <= 11'd0;
    end else begin
      px_cnt_r <= px_cnt_r;
    end
  end

  assign pop_s   = wr_valid && wr_ready;
  assign full_s  = (count_r == CW'(FIFO_DEPTH));
  assign wr_en_s = push_s && (!full_s || pop_s);
  assign drop_s  = push_s && full_s && !pop_s;
  assign wr_data = mem_r[rd_ptr_r];

  // FIFO occupancy next value
  always_comb begin
    count_n = count_r;
    case ({wr_en_s, pop_s})
      2'b10:   count_n = count_r + CW'(1);
      2'b01:   count_n = count_r - CW'(1);
      default: count_n = count_r;
    endcase
  end

  // FIFO storage, pointers and overflow flag
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= 32'h0000_0000;
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      wr_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= push_data_s;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r  <= count_n;
      wr_valid <= (count_n != {CW{1'b0}});
      if (drop_s)       overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
      else              overflow <= overflow;
    end
  end

endmodule

// File: tb/tb_rgb_video_capture.sv
// Directed bench for rgb_video_capture: an active-high and an active-low vsync instance
// are driven with the same stream and must agree with hand-computed results.
module tb_rgb_video_capture;

  logic        clk = 1'b0;
  logic        rst, capture_en, ovf_clr, vs, hs, de, wr_ready;
  logic [15:0] rgb;
  logic [31:0] wr_data_o [2];
  logic        wr_valid_o [2];
  logic        fs_o [2];
  logic        fd_o [2];
  logic        mv_o [2];
  logic        ovf_o [2];
  logic [10:0] h_o [2];
  logic [10:0] v_o [2];

  logic [31:0] wq0 [$];
  logic [31:0] wq1 [$];
  logic [31:0] exp_q [$];
  int          fs_cnt [2] = '{0, 0};
  int          fd_cnt [2] = '{0, 0};
  int          total = 0;
  int          bad = 0;
  int          b0, b1, fsb, fdb;

  always #5 clk = ~clk;

  rgb_video_capture #(.VS_POL(1'b1), .FIFO_DEPTH(16)) u_dut_p (
    .sys_clk(clk), .sys_rst(rst), .capture_en(capture_en), .ovf_clr(ovf_clr),
    .vid_vs(vs), .vid_hs(hs), .vid_de(de), .vid_rgb(rgb),
    .wr_data(wr_data_o[0]), .wr_valid(wr_valid_o[0]), .wr_ready(wr_ready),
    .frame_start(fs_o[0]), .frame_done(fd_o[0]), .h_meas(h_o[0]), .v_meas(v_o[0]),
    .meas_valid(mv_o[0]), .overflow(ovf_o[0])
  );

  rgb_video_capture #(.VS_POL(1'b0), .FIFO_DEPTH(16)) u_dut_n (
    .sys_clk(clk), .sys_rst(rst), .capture_en(capture_en), .ovf_clr(ovf_clr),
    .vid_vs(~vs), .vid_hs(hs), .vid_de(de), .vid_rgb(rgb),
    .wr_data(wr_data_o[1]), .wr_valid(wr_valid_o[1]), .wr_ready(wr_ready),
    .frame_start(fs_o[1]), .frame_done(fd_o[1]), .h_meas(h_o[1]), .v_meas(v_o[1]),
    .meas_valid(mv_o[1]), .overflow(ovf_o[1])
  );

  // collect popped words and frame pulses away from the active edge
  always @(negedge clk) begin
    if (wr_valid_o[0] && wr_ready) wq0.push_back(wr_data_o[0]);
    if (wr_valid_o[1] && wr_ready) wq1.push_back(wr_data_o[1]);
    if (fs_o[0]) fs_cnt[0]++;
    if (fs_o[1]) fs_cnt[1]++;
    if (fd_o[0]) fd_cnt[0]++;
    if (fd_o[1]) fd_cnt[1]++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_line(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      de  = 1'b1;
      rgb = base + 16'(i);
      tick();
    end
    de  = 1'b0;
    rgb = 16'h0000;
    hs  = 1'b1;
    tick();
    hs  = 1'b0;
    tick();
    tick();
  endtask

  // vsync pulse; frame pulses must appear exactly two cycles after vs goes active
  task automatic vs_pulse(input string tag, input logic exp_fs, input logic exp_fd);
    vs = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) begin
      check_val({tag, ".fs_early"}, {31'd0, fs_o[d]}, 32'd0);
    end
    tick();
    for (int d = 0; d < 2; d++) begin
      check_val({tag, ".fs"}, {31'd0, fs_o[d]}, {31'd0, exp_fs});
      check_val({tag, ".fd"}, {31'd0, fd_o[d]}, {31'd0, exp_fd});
    end
    vs = 1'b0;
    tick();
    tick();
  endtask

  task automatic check_words(input string tag, input int base0, input int base1);
    check_val({tag, ".n_p"}, 32'(wq0.size() - base0), 32'(exp_q.size()));
    check_val({tag, ".n_n"}, 32'(wq1.size() - base1), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      check_val({tag, ".w_p"}, (base0 + i < wq0.size()) ? wq0[base0 + i] : 32'hDEAD_DEAD, exp_q[i]);
      check_val({tag, ".w_n"}, (base1 + i < wq1.size()) ? wq1[base1 + i] : 32'hDEAD_DEAD, exp_q[i]);
    end
  endtask

  task automatic check_meas(input string tag, input logic [10:0] h, input logic [10:0] v,
                            input logic mv);
    for (int d = 0; d < 2; d++) begin
      check_val({tag, ".h"}, {21'd0, h_o[d]}, {21'd0, h});
      check_val({tag, ".v"}, {21'd0, v_o[d]}, {21'd0, v});
      check_val({tag, ".mv"}, {31'd0, mv_o[d]}, {31'd0, mv});
    end
  endtask

  initial begin
    rst = 1'b1; capture_en = 1'b0; ovf_clr = 1'b0; vs = 1'b0; hs = 1'b0;
    de = 1'b0; rgb = 16'h0000; wr_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    for (int d = 0; d < 2; d++) begin
      check_val("rst.valid", {31'd0, wr_valid_o[d]}, 32'd0);
      check_val("rst.data", wr_data_o[d], 32'h0000_0000);
      check_val("rst.fs", {31'd0, fs_o[d]}, 32'd0);
      check_val("rst.fd", {31'd0, fd_o[d]}, 32'd0);
      check_val("rst.ovf", {31'd0, ovf_o[d]}, 32'd0);
    end
    check_meas("rst", 11'd0, 11'd0, 1'b0);

    // 4x3 frame: the frame before the first vs edge is ignored
    capture_en = 1'b1;
    tick();
    tick();
    send_line(4, 16'h0F01);
    send_line(4, 16'h0F05);
    send_line(4, 16'h0F09);
    b0 = wq0.size(); b1 = wq1.size(); fdb = fd_cnt[0];
    vs_pulse("t1.vs1", 1'b1, 1'b0);
    send_line(4, 16'h0001);
    send_line(4, 16'h0005);
    send_line(4, 16'h0009);
    vs_pulse("t1.vs2", 1'b1, 1'b1);
    exp_q.delete();
    exp_q.push_back(32'h0002_0001); exp_q.push_back(32'h0004_0003);
    exp_q.push_back(32'h0006_0005); exp_q.push_back(32'h0008_0007);
    exp_q.push_back(32'h000A_0009); exp_q.push_back(32'h000C_000B);
    check_words("t1.words", b0, b1);
    check_meas("t1.meas", 11'd4, 11'd3, 1'b1);
    check_val("t1.fd_count", 32'(fd_cnt[0] - fdb), 32'd1);

    // odd width 3x2
    b0 = wq0.size(); b1 = wq1.size();
    send_line(3, 16'hA001);
    send_line(3, 16'hB001);
    vs_pulse("t2.vs", 1'b1, 1'b1);
    exp_q.delete();
    exp_q.push_back(32'hA002_A001); exp_q.push_back(32'h0000_A003);
    exp_q.push_back(32'hB002_B001); exp_q.push_back(32'h0000_B003);
    check_words("t2.words", b0, b1);
    check_meas("t2.meas", 11'd3, 11'd2, 1'b1);

    // latency: pair completed at cycle t shows as wr_valid at t+3
    wr_ready = 1'b0;
    de = 1'b1; rgb = 16'h1111;
    tick();
    rgb = 16'h2222;
    tick();
    de = 1'b0; rgb = 16'h0000;
    check_val("t3.valid_t1", {31'd0, wr_valid_o[0]}, 32'd0);
    tick();
    check_val("t3.valid_t2", {31'd0, wr_valid_o[0]}, 32'd0);
    tick();
    check_val("t3.valid_t3", {31'd0, wr_valid_o[0]}, 32'd1);
    check_val("t3.data_t3", wr_data_o[0], 32'h2222_1111);
    send_line(1, 16'h3333);
    tick();
    check_val("t3.data_hold", wr_data_o[1], 32'h2222_1111);
    b0 = wq0.size(); b1 = wq1.size();
    wr_ready = 1'b1;
    tick(); tick(); tick();
    exp_q.delete();
    exp_q.push_back(32'h2222_1111); exp_q.push_back(32'h0000_3333);
    check_words("t3.words", b0, b1);
    check_val("t3.empty", {31'd0, wr_valid_o[0]}, 32'd0);
    vs_pulse("t3.vs", 1'b1, 1'b1);
    check_meas("t3.meas", 11'd2, 11'd2, 1'b1);

    // overflow: 40 pixels into a 16-word FIFO with no consumer
    wr_ready = 1'b0;
    send_line(40, 16'h0400);
    tick();
    for (int d = 0; d < 2; d++) begin
      check_val("t4.ovf_set", {31'd0, ovf_o[d]}, 32'd1);
      check_val("t4.valid", {31'd0, wr_valid_o[d]}, 32'd1);
      check_val("t4.head", wr_data_o[d], 32'h0401_0400);
    end
    b0 = wq0.size(); b1 = wq1.size();
    wr_ready = 1'b1;
    repeat (20) tick();
    exp_q.delete();
    for (int k = 0; k < 16; k++) begin
      exp_q.push_back({16'h0400 + 16'(2 * k + 1), 16'h0400 + 16'(2 * k)});
    end
    check_words("t4.drain", b0, b1);
    check_val("t4.ovf_sticky", {31'd0, ovf_o[0]}, 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    tick();
    for (int d = 0; d < 2; d++) begin
      check_val("t4.ovf_clr", {31'd0, ovf_o[d]}, 32'd0);
    end
    vs_pulse("t4.vs", 1'b1, 1'b1);
    check_meas("t4.meas", 11'd40, 11'd1, 1'b1);

    // capture_en dropped mid-frame: frame completes, then capture stops
    b0 = wq0.size(); b1 = wq1.size();
    send_line(2, 16'h5001);
    capture_en = 1'b0;
    send_line(2, 16'h5003);
    vs_pulse("t5.vs1", 1'b0, 1'b1);
    exp_q.delete();
    exp_q.push_back(32'h5002_5001); exp_q.push_back(32'h5004_5003);
    check_words("t5.words", b0, b1);
    check_meas("t5.meas", 11'd2, 11'd2, 1'b1);
    b0 = wq0.size(); b1 = wq1.size(); fsb = fs_cnt[0];
    send_line(2, 16'h6001);
    send_line(2, 16'h6003);
    vs_pulse("t5.vs2", 1'b0, 1'b0);
    exp_q.delete();
    check_words("t5.idle_words", b0, b1);
    check_val("t5.fs_count", 32'(fs_cnt[0] - fsb), 32'd0);
    check_meas("t5.meas_hold", 11'd2, 11'd2, 1'b1);

    // reset in the middle of line 2
    wr_ready = 1'b0;
    capture_en = 1'b1;
    tick();
    tick();
    vs_pulse("t6.vs1", 1'b1, 1'b0);
    send_line(4, 16'h7001);
    check_val("t6.valid_pre", {31'd0, wr_valid_o[0]}, 32'd1);
    de = 1'b1; rgb = 16'h7005;
    tick();
    rgb = 16'h7006;
    tick();
    rgb = 16'h7007; rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check_val("t6.rst_valid", {31'd0, wr_valid_o[d]}, 32'd0);
      check_val("t6.rst_mv", {31'd0, mv_o[d]}, 32'd0);
    end
    rgb = 16'h7008;
    tick();
    de = 1'b0; rgb = 16'h0000;
    tick(); tick();
    send_line(4, 16'h7009);
    tick(); tick(); tick();
    for (int d = 0; d < 2; d++) begin
      check_val("t6.no_words", {31'd0, wr_valid_o[d]}, 32'd0);
    end
    wr_ready = 1'b1;
    b0 = wq0.size(); b1 = wq1.size();
    vs_pulse("t6.vs2", 1'b1, 1'b0);
    send_line(2, 16'h8001);
    send_line(2, 16'h8003);
    vs_pulse("t6.vs3", 1'b1, 1'b1);
    exp_q.delete();
    exp_q.push_back(32'h8002_8001); exp_q.push_back(32'h8004_8003);
    check_words("t6.words", b0, b1);
    check_meas("t6.meas", 11'd2, 11'd2, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
